// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard_pkg
// Description : Register-number width, register count and zero-register
//               index shared by decode and the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_scoreboard_pkg;

    localparam int c_REG_W    = 5;
    localparam int c_NREG     = 32;
    localparam int c_ZERO_REG = 0;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Saturating up/down pending-write counter with sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_nonzero,
    output logic o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec_ok;

    assign o_full      = &r_cnt;
    assign o_nonzero   = |r_cnt;
    assign w_dec_ok    = i_dec & o_nonzero;
    assign o_underflow = i_dec & ~o_nonzero;

    // Simultaneous reserve and release hold, even when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && w_dec_ok) begin
            r_cnt <= r_cnt;
        end else if (i_inc) begin
            if (!o_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_dec_ok) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : RAW/WAW register-hazard scoreboard between decode and
//               writeback; one pending-write counter per register.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = c_NREG,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [c_REG_W-1:0] r0num_i,
    input  logic               r0valid_i,
    input  logic [c_REG_W-1:0] r1num_i,
    input  logic               r1valid_i,
    input  logic [c_REG_W-1:0] rdnum_i,
    input  logic               rdreserve_i,
    input  logic               wb_valid_i,
    input  logic [c_REG_W-1:0] wb_rdnum_i,
    input  logic               flush_i,
    output logic               rsreserved_o,
    output logic [NREG-1:0]    busy_o,
    output logic               underflow_o
);

    logic [NREG-1:0] w_busy;
    logic [NREG-1:0] w_full;
    logic [NREG-1:0] w_uf;
    logic            r_underflow;

    assign w_busy[c_ZERO_REG] = 1'b0;
    assign w_full[c_ZERO_REG] = 1'b0;
    assign w_uf[c_ZERO_REG]   = 1'b0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_reg
            logic w_inc;
            logic w_dec;

            assign w_inc = rdreserve_i & (rdnum_i == c_REG_W'(i));
            assign w_dec = wb_valid_i & (wb_rdnum_i == c_REG_W'(i));

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_clr       (flush_i),
                .i_inc       (w_inc),
                .i_dec       (w_dec),
                .o_full      (w_full[i]),
                .o_nonzero   (w_busy[i]),
                .o_underflow (w_uf[i])
            );
        end
    endgenerate

    // No writeback bypass: the stall is a function of registered state only.
    assign rsreserved_o = (r0valid_i & w_busy[r0num_i])
                        | (r1valid_i & w_busy[r1num_i])
                        | w_full[rdnum_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (|w_uf) begin
            r_underflow <= 1'b1;
        end
    end

    assign busy_o      = w_busy;
    assign underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Self-checking bench for reg_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  r0num, r1num, rdnum, wb_rdnum;
    logic        r0valid, r1valid, rdreserve, wb_valid, flush;
    logic        rsreserved;
    logic [31:0] busy;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    int mcnt [32];
    bit muf;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .NREG  (32),
        .CNT_W (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r0num_i      (r0num),
        .r0valid_i    (r0valid),
        .r1num_i      (r1num),
        .r1valid_i    (r1valid),
        .rdnum_i      (rdnum),
        .rdreserve_i  (rdreserve),
        .wb_valid_i   (wb_valid),
        .wb_rdnum_i   (wb_rdnum),
        .flush_i      (flush),
        .rsreserved_o (rsreserved),
        .busy_o       (busy),
        .underflow_o  (underflow)
    );

    // Reference model: integer pending-write count per register, max 3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) mcnt[r] <= 0;
            muf <= 1'b0;
        end else begin
            if (wb_valid && wb_rdnum != 0 && mcnt[wb_rdnum] == 0) muf <= 1'b1;
            for (int r = 1; r < 32; r++) begin
                if (flush) begin
                    mcnt[r] <= 0;
                end else if ((rdreserve && rdnum == r) &&
                             !(wb_valid && wb_rdnum == r && mcnt[r] > 0)) begin
                    mcnt[r] <= (mcnt[r] >= 3) ? 3 : mcnt[r] + 1;
                end else if (!(rdreserve && rdnum == r) &&
                             (wb_valid && wb_rdnum == r && mcnt[r] > 0)) begin
                    mcnt[r] <= mcnt[r] - 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        exp_rs;
        logic [31:0] exp_busy;
        exp_rs = (r0valid && mcnt[r0num] != 0) || (r1valid && mcnt[r1num] != 0) ||
                 (rdnum != 0 && mcnt[rdnum] == 3);
        for (int r = 0; r < 32; r++) exp_busy[r] = (mcnt[r] != 0);
        n_tests = n_tests + 3;
        if (rsreserved !== exp_rs) begin
            n_fail++;
            $display("FAIL model_rsreserved t=%0t got %b exp %b", $time, rsreserved, exp_rs);
        end
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL model_busy t=%0t got %h exp %h", $time, busy, exp_busy);
        end
        if (underflow !== muf) begin
            n_fail++;
            $display("FAIL model_underflow t=%0t got %b exp %b", $time, underflow, muf);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic idle();
        r0num = 0; r0valid = 0; r1num = 0; r1valid = 0;
        rdnum = 0; rdreserve = 0; wb_valid = 0; wb_rdnum = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reserve(input logic [4:0] r);
        idle();
        rdreserve = 1; rdnum = r;
        tick();
    endtask

    task automatic release_reg(input logic [4:0] r);
        idle();
        wb_valid = 1; wb_rdnum = r;
        tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("idle_rs", 32'(rsreserved), 32'd0);
        chk("idle_busy", busy, 32'd0);
        chk("idle_uf", 32'(underflow), 32'd0);

        // RAW on x5, released three cycles later
        reserve(5);
        idle(); r0valid = 1; r0num = 5; #1;
        chk("raw5_stall", 32'(rsreserved), 32'd1);
        chk("raw5_busy", 32'(busy[5]), 32'd1);
        tick(); tick();
        wb_valid = 1; wb_rdnum = 5; #1;
        chk("raw5_no_bypass", 32'(rsreserved), 32'd1);
        tick();
        wb_valid = 0; #1;
        chk("raw5_cleared", 32'(rsreserved), 32'd0);
        chk("raw5_not_busy", 32'(busy[5]), 32'd0);

        // WAW saturation on x7
        reserve(7); reserve(7); reserve(7);
        idle(); rdnum = 7; #1;
        chk("waw7_full_stall", 32'(rsreserved), 32'd1);
        reserve(7);
        idle(); rdnum = 7; #1;
        chk("waw7_saturated", 32'(rsreserved), 32'd1);
        release_reg(7);
        idle(); rdnum = 7; #1;
        chk("waw7_stall_clear", 32'(rsreserved), 32'd0);
        chk("waw7_still_busy", 32'(busy[7]), 32'd1);
        release_reg(7); release_reg(7);
        idle(); #1;
        chk("waw7_idle", 32'(busy[7]), 32'd0);

        // Same-cycle reserve/release of x9, and writes to x0
        reserve(9);
        idle(); rdreserve = 1; rdnum = 9; wb_valid = 1; wb_rdnum = 9;
        tick();
        idle(); #1;
        chk("x9_hold_busy", 32'(busy[9]), 32'd1);
        release_reg(9);
        chk("x9_released", 32'(busy[9]), 32'd0);
        idle(); rdreserve = 1; rdnum = 0; wb_valid = 1; wb_rdnum = 0;
        tick();
        idle(); r0valid = 1; r0num = 0; #1;
        chk("x0_stall", 32'(rsreserved), 32'd0);
        chk("x0_busy", busy, 32'd0);
        chk("x0_uf", 32'(underflow), 32'd0);

        // Underflow on x12 is sticky through flush
        release_reg(12);
        chk("uf_set", 32'(underflow), 32'd1);
        idle(); flush = 1;
        tick();
        chk("uf_thru_flush", 32'(underflow), 32'd1);

        // Flush overrides simultaneous reserve
        reserve(3); reserve(4); reserve(6);
        idle(); #1;
        chk("pre_flush_busy", busy, 32'h0000_0058);
        idle(); flush = 1; rdreserve = 1; rdnum = 8;
        tick();
        idle(); r0valid = 1; r0num = 3; #1;
        chk("flush_busy", busy, 32'd0);
        chk("flush_rs", 32'(rsreserved), 32'd0);

        // Asynchronous reset mid-sequence
        reserve(10);
        idle(); r0valid = 1; r0num = 10; #1;
        chk("pre_rst_stall", 32'(rsreserved), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rs", 32'(rsreserved), 32'd0);
        chk("async_busy", busy, 32'd0);
        chk("async_uf", 32'(underflow), 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard that owns the architectural register file's read-after-write and write-after-write interlock for the in-order pipeline. Decode presents its source and destination register numbers each cycle; the block answers with a single stall (`rsreserved_o`), records destination reservations, and releases them when writeback retires the result. It sits beside the register file, between the decode stage and the writeback stage, and is the sole arbiter of when an instruction may leave decode.

## Interface
- `NREG`, 32, number of architectural registers; register 0 is hard-wired zero.
- `CNT_W`, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^CNT_W − 1.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `r0num_i`  in  5  decode source-1 register number.
- `r0valid_i`  in  1  source-1 is read by the decoding instruction.
- `r1num_i`  in  5  decode source-2 register number.
- `r1valid_i`  in  1  source-2 is read.
- `rdnum_i`  in  5  decode destination register number.
- `rdreserve_i`  in  1  decode is issuing an instruction that writes `rdnum_i` this cycle.
- `wb_valid_i`  in  1  writeback retires a result this cycle.
- `wb_rdnum_i`  in  5  register being written back.
- `flush_i`  in  1  pipeline flush; discard all reservations.
- `rsreserved_o`  out  1  stall decode: hazard on a source or destination counter full.
- `busy_o`  out  NREG  bit i = register i has ≥1 pending write.
- `underflow_o`  out  1  sticky error: release of a register with zero pending writes.

## Operation
- State: NREG counters `cnt[i]` (CNT_W bits); `cnt[0]` constant 0.
- `rsreserved_o` (combinational from state + decode inputs) = (`r0valid_i` & `cnt[r0num_i]`≠0) | (`r1valid_i` & `cnt[r1num_i]`≠0) | (`rdnum_i`≠0 & `cnt[rdnum_i]` = all-ones). Must not depend on `rdreserve_i` or `wb_*` (no comb loop with decode, no same-cycle bypass).
- Per register i≠0, per edge: inc = `rdreserve_i` & `rdnum_i`=i; dec = `wb_valid_i` & `wb_rdnum_i`=i & `cnt[i]`≠0.
  - inc & ~dec → +1; dec & ~inc → −1; both or neither → hold.
  - inc when `cnt[i]` = all-ones: ignored (decode protocol violation; counter saturates, no wrap).
- Writes to register 0 (reserve or release) are ignored; never busy, never stall.
- `wb_valid_i` with `cnt[wb_rdnum_i]`=0 and `wb_rdnum_i`≠0: counter holds at 0, `underflow_o` sets and stays 1 until reset.
- `flush_i`: all counters → 0 next edge; overrides simultaneous inc/dec. `underflow_o` unaffected.
- `busy_o[i]` = `cnt[i]`≠0; `busy_o[0]` = 0.

## Timing
- Reset (`rst_n` low, async): all `cnt` = 0, `underflow_o` = 0; hence `rsreserved_o` = 0 (when no state), `busy_o` = 0. Reset mid-operation discards all reservations immediately.
- Reserve accepted at edge N → `busy_o` and stall on that register visible from cycle N+1.
- Release at edge N → stall drops in cycle N+1 (one-cycle writeback-to-decode latency, no bypass).
- Reserve and release of the same register in one cycle → count unchanged, busy state unchanged.
- Flush at edge N → `busy_o` = 0 and `rsreserved_o` = 0 from cycle N+1.

## Structure
- Shared include (alongside the instruction field definitions): register-number width (5), `NREG`, zero-register index.
- One sub-module: `sb_counter` — CNT_W-bit saturating up/down counter with sync clear, async active-low reset, full/nonzero/underflow outputs; generated for registers 1..NREG−1.
- Top: index decoders for inc/dec, 3-way read mux for hazard check, underflow OR-reduce into sticky flop.

## Test plan
- Reset then idle: `rsreserved_o`=0, `busy_o`=0, `underflow_o`=0 for 10 cycles.
- Reserve x5 (edge N), decode reads r0num=5 in N+1 → `rsreserved_o`=1; wb x5 at N+3 → `rsreserved_o`=0 in N+4, `busy_o[5]`=0.
- Three reserves of x7 (CNT_W=2) → `cnt`=3, decode with rdnum=7 stalls; one wb → stall clears; two more wb → `busy_o[7]`=0.
- Same-cycle reserve x9 and wb x9 with cnt=1 → `busy_o[9]` stays 1; reserve/release of x0 → `busy_o`=0, no stall, no underflow.
- wb x12 with cnt=0 → `underflow_o`=1, stays 1 through flush, clears only on `rst_n`.
- Reserve x3,x4,x6 then `flush_i` with simultaneous reserve x8 → `busy_o`=0 next cycle; assert `rst_n` low mid-sequence → all outputs 0 asynchronously.
